// File: rtl/axi_exclusive_sram.sv
// axi_exclusive_sram
//   Single-beat AXI slave that acts as the local data memory for loads, stores
//   and atomics. It holds DEPTH_WORDS x 32-bit byte-enabled storage at base
//   address 0, plus a one-entry exclusive-access monitor. An exclusive read
//   (arlock) records a reservation. An exclusive write (awlock) is performed
//   and answered with EXOKAY only while that reservation still holds.
//   Otherwise the write is dropped and answered with OKAY. Only one
//   transaction is in flight at a time.
//
// Parameters
//   DEPTH_WORDS   number of 32-bit words (power of two)
//   READ_LATENCY  cycles from AR acceptance to the SRAM fetch (1..4)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   araddr/arvalid/arready   read address channel; arlock marks an exclusive read
//   arlen/arburst/arid       accepted but ignored (single beat only)
//   rdata/rresp/rvalid/rready read data channel (rresp 00 OKAY, 10 SLVERR)
//   awaddr/awvalid/awready   write address channel; awlock marks an exclusive write
//   wdata/wstrb/wvalid/wready write data channel with byte enables
//   bresp/bvalid/bready      write response (00 OKAY, 01 EXOKAY, 10 SLVERR)
module axi_exclusive_sram #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic        arlock,
  input  logic [7:0]  arlen,
  input  logic [1:0]  arburst,
  input  logic        arid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic        awlock,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    READ_RESP,
    WRITE_COLLECT,
    WRITE_RESP
  } state_t;

  state_t state;

  // Control registers (reset)
  logic [CNT_W-1:0] lat_cnt;
  logic             rd_fetched;
  logic             aw_have;
  logic             w_have;
  logic             resv_valid;
  logic [29:0]      resv_addr;

  // Captured transaction data (not reset)
  logic [29:0]      rd_addr;
  logic             rd_lock;
  logic [29:0]      wr_addr;
  logic             wr_lock;
  logic [31:0]      wr_data;
  logic [3:0]       wr_strb;
  logic [31:0]      rd_word_p0;

  logic [31:0]      mem [DEPTH_WORDS];

  logic ar_hs;
  logic aw_hs;
  logic w_hs;
  logic rd_in_range;
  logic wr_in_range;
  logic wr_hit;
  logic commit;
  logic mem_we;
  logic rd_fetch;

  // Burst and ID fields are never needed for a single-beat target.
  logic unused_ok;
  assign unused_ok = ^{arlen, arburst, arid, araddr[1:0], awaddr[1:0]};

  // Reads only start when no write is pending, which gives writes priority.
  assign arready = (state == IDLE) && !awvalid && !wvalid;
  assign awready = (state == IDLE) || ((state == WRITE_COLLECT) && !aw_have);
  assign wready  = (state == IDLE) || ((state == WRITE_COLLECT) && !w_have);

  assign ar_hs = arvalid && arready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // A word index is in range when no address bit above the index field is set.
  assign rd_in_range = (rd_addr >> IDX_W) == 30'd0;
  assign wr_in_range = (wr_addr >> IDX_W) == 30'd0;
  assign wr_hit      = resv_valid && (resv_addr == wr_addr);

  // The commit edge is the first edge on which both AW and W are already held.
  assign commit   = (state == WRITE_COLLECT) && aw_have && w_have;
  assign mem_we   = commit && wr_in_range && (!wr_lock || wr_hit);
  assign rd_fetch = (state == READ_WAIT) && !rd_fetched && (lat_cnt == '0);

  // Stage p0: channel capture
  always_ff @(posedge clk) begin
    if (ar_hs) begin
      rd_addr <= araddr[31:2];
      rd_lock <= arlock;
    end
    if (aw_hs) begin
      wr_addr <= awaddr[31:2];
      wr_lock <= awlock;
    end
    if (w_hs) begin
      wr_data <= wdata;
      wr_strb <= wstrb;
    end
  end

  // Stage p0: SRAM array, byte-masked write and synchronous read fetch.
  // Reset blocks the commit edge so an abandoned write never lands.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) begin
          mem[wr_addr[IDX_W-1:0]][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
    if (rd_fetch) begin
      rd_word_p0 <= rd_in_range ? mem[rd_addr[IDX_W-1:0]] : '0;
    end
  end

  // Stage p1: transaction control, responses and exclusive monitor
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      rd_fetched <= 1'b0;
      aw_have    <= 1'b0;
      w_have     <= 1'b0;
      resv_valid <= 1'b0;
      rvalid     <= 1'b0;
      rresp      <= RESP_OKAY;
      rdata      <= '0;
      bvalid     <= 1'b0;
      bresp      <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs || w_hs) begin
            aw_have <= aw_hs;
            w_have  <= w_hs;
            state   <= WRITE_COLLECT;
          end else if (ar_hs) begin
            lat_cnt    <= CNT_W'(READ_LATENCY - 1);
            rd_fetched <= 1'b0;
            state      <= READ_WAIT;
          end
        end

        READ_WAIT: begin
          if (!rd_fetched) begin
            if (lat_cnt == '0) begin
              rd_fetched <= 1'b1;
            end else begin
              lat_cnt <= lat_cnt - CNT_W'(1);
            end
          end else begin
            // The fetched word is presented one edge after the SRAM access.
            rdata  <= rd_word_p0;
            rresp  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            rvalid <= 1'b1;
            if (rd_lock && rd_in_range) begin
              resv_valid <= 1'b1;
              resv_addr  <= rd_addr;
            end
            state <= READ_RESP;
          end
        end

        READ_RESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            state  <= IDLE;
          end
        end

        WRITE_COLLECT: begin
          if (commit) begin
            if (!wr_in_range) begin
              bresp <= RESP_SLVERR;
            end else if (wr_lock) begin
              // Any exclusive write attempt consumes the reservation.
              bresp      <= wr_hit ? RESP_EXOKAY : RESP_OKAY;
              resv_valid <= 1'b0;
            end else begin
              bresp <= RESP_OKAY;
              if (wr_hit) begin
                resv_valid <= 1'b0;
              end
            end
            aw_have <= 1'b0;
            w_have  <= 1'b0;
            bvalid  <= 1'b1;
            state   <= WRITE_RESP;
          end else begin
            if (aw_hs) begin
              aw_have <= 1'b1;
            end
            if (w_hs) begin
              w_have <= 1'b1;
            end
          end
        end

        WRITE_RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_exclusive_sram.sv
// Testbench for axi_exclusive_sram: directed steps followed by a randomized
// phase checked against a behavioural model of memory and reservation.
module tb_axi_exclusive_sram;

  localparam int DEPTH = 1024;
  localparam int RL    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic        arlock;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        arid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic        awlock;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  logic [31:0] model_mem [int];
  bit          model_resv_v;
  logic [29:0] model_resv_a;

  axi_exclusive_sram #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arlock(arlock),
    .arlen(arlen), .arburst(arburst), .arid(arid),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awlock(awlock),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit model_in_range(input logic [31:0] a);
    return (a >> 2) < 32'(DEPTH);
  endfunction

  function automatic void model_read(input logic [31:0] a, input bit lock,
                                     output logic [31:0] ed, output logic [1:0] er);
    int w;
    w = int'(a >> 2);
    if (!model_in_range(a)) begin
      ed = 32'd0;
      er = 2'b10;
    end else begin
      ed = model_mem.exists(w) ? model_mem[w] : 32'd0;
      er = 2'b00;
      if (lock) begin
        model_resv_v = 1'b1;
        model_resv_a = a[31:2];
      end
    end
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s, input bit lock,
                                      output logic [1:0] er);
    logic [31:0] old;
    bit          hit;
    bit          do_wr;
    int          w;
    w     = int'(a >> 2);
    hit   = model_resv_v && (model_resv_a == a[31:2]);
    do_wr = 1'b0;
    if (!model_in_range(a)) begin
      er = 2'b10;
    end else if (lock) begin
      er           = hit ? 2'b01 : 2'b00;
      do_wr        = hit;
      model_resv_v = 1'b0;
    end else begin
      er    = 2'b00;
      do_wr = 1'b1;
      if (hit) model_resv_v = 1'b0;
    end
    if (do_wr) begin
      old = model_mem.exists(w) ? model_mem[w] : 32'd0;
      for (int b = 0; b < 4; b++) if (s[b]) old[8*b +: 8] = d[8*b +: 8];
      model_mem[w] = old;
    end
  endfunction

  // Called at a negedge; returns at a negedge after the R handshake.
  task automatic axi_read(input logic [31:0] addr, input bit lock, input int hold,
                          output logic [31:0] data, output logic [1:0] resp, output int lat);
    int n;
    araddr  = addr;
    arlock  = lock;
    arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("ar_accept", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("r_seen", 32'(rvalid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("r_hold_valid", 32'(rvalid), 32'd1);
    end
    data   = rdata;
    resp   = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("r_done", 32'(rvalid), 32'd0);
  endtask

  // Called at a negedge; W is raised w_delay cycles after AW is first offered.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input bit lock, input int w_delay,
                           output logic [1:0] resp);
    bit aw_done, w_done, aw_fire, w_fire;
    int cyc, n;
    awaddr  = addr;
    awlock  = lock;
    wdata   = data;
    wstrb   = strb;
    awvalid = 1'b1;
    wvalid  = (w_delay == 0);
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc     = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      #1;
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(negedge clk);
      if (aw_fire) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_fire)  begin wvalid  = 1'b0; w_done  = 1'b1; end
      cyc++;
      if (cyc == w_delay && !w_done) wvalid = 1'b1;
    end
    check("aw_w_accept", 32'({aw_done, w_done}), 32'd3);
    n = 0;
    while (!bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("b_seen", 32'(bvalid), 32'd1);
    resp   = bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("b_single", 32'(bvalid), 32'd0);
  endtask

  initial begin
    logic [31:0] d, a, ed;
    logic [1:0]  r, er;
    logic [3:0]  s;
    int          lat, n, k, op, wd, hd;
    bit          lk;

    rst = 1'b1;
    araddr = '0; arvalid = 1'b0; arlock = 1'b0; arlen = '0; arburst = 2'b01; arid = 1'b0;
    rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; awlock = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rresp", 32'(rresp), 32'd0);
    check("rst_bresp", 32'(bresp), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_arready", 32'(arready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Basic write then read with latency check
    axi_write(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 0, r);
    check("wr10_bresp", 32'(r), 32'd0);
    axi_read(32'h10, 1'b0, 0, d, r, lat);
    check("rd10_data", d, 32'hDEADBEEF);
    check("rd10_rresp", 32'(r), 32'd0);
    check("rd10_latency", 32'(lat), 32'(RL + 1));

    // Exclusive pair succeeds once, repeat fails
    axi_write(32'h20, 32'd0, 4'hF, 1'b0, 0, r);
    axi_read(32'h20, 1'b1, 0, d, r, lat);
    check("exrd20_data", d, 32'd0);
    axi_write(32'h20, 32'd5, 4'hF, 1'b1, 0, r);
    check("exwr5_bresp", 32'(r), 32'd1);
    axi_read(32'h20, 1'b0, 0, d, r, lat);
    check("mem20_is5", d, 32'd5);
    axi_write(32'h20, 32'd6, 4'hF, 1'b1, 0, r);
    check("exwr6_bresp", 32'(r), 32'd0);
    axi_read(32'h20, 1'b0, 0, d, r, lat);
    check("mem20_still5", d, 32'd5);

    // Plain write to the reserved address kills the reservation
    axi_read(32'h20, 1'b1, 0, d, r, lat);
    axi_write(32'h20, 32'd7, 4'hF, 1'b0, 0, r);
    check("plainwr7_bresp", 32'(r), 32'd0);
    axi_write(32'h20, 32'd9, 4'hF, 1'b1, 0, r);
    check("exwr9_bresp", 32'(r), 32'd0);
    axi_read(32'h20, 1'b0, 0, d, r, lat);
    check("mem20_is7", d, 32'd7);

    // Exclusive write with wstrb=0 succeeds but changes nothing
    axi_read(32'h20, 1'b1, 0, d, r, lat);
    axi_write(32'h20, 32'hFFFFFFFF, 4'h0, 1'b1, 0, r);
    check("exwr_nostrb_bresp", 32'(r), 32'd1);
    axi_read(32'h20, 1'b0, 0, d, r, lat);
    check("mem20_nostrb", d, 32'd7);

    // AW three cycles ahead of W, single byte lane
    axi_write(32'h30, 32'h11223344, 4'hF, 1'b0, 0, r);
    axi_write(32'h30, 32'hAABBCCDD, 4'b0010, 1'b0, 3, r);
    check("late_w_bresp", 32'(r), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_w_no_extra_b", 32'(bvalid), 32'd0);
    end
    axi_read(32'h30, 1'b0, 0, d, r, lat);
    check("mem30_merged", d, 32'h1122CC44);

    // Read and write offered together: write goes first
    araddr = 32'h10; arlock = 1'b0; arvalid = 1'b1;
    awaddr = 32'h40; awlock = 1'b0; awvalid = 1'b1;
    wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
    #1;
    check("conc_arready_low", 32'(arready), 32'd0);
    check("conc_awready", 32'(awready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    #1;
    check("conc_arready_collect", 32'(arready), 32'd0);
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("conc_b_seen", 32'(bvalid), 32'd1);
    check("conc_bresp", 32'(bresp), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("conc_arready_bwait", 32'(arready), 32'd0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    #1;
    check("conc_arready_after_b", 32'(arready), 32'd1);
    axi_read(32'h10, 1'b0, 5, d, r, lat);
    check("conc_rd_data_held", d, 32'hDEADBEEF);
    check("conc_rd_rresp", 32'(r), 32'd0);
    axi_read(32'h40, 1'b0, 0, d, r, lat);
    check("mem40", d, 32'h0BADF00D);

    // Out-of-range access leaves the reservation alone
    axi_read(32'h40, 1'b1, 0, d, r, lat);
    axi_read(32'(4 * DEPTH), 1'b0, 0, d, r, lat);
    check("oor_rd_rresp", 32'(r), 32'd2);
    check("oor_rd_data", d, 32'd0);
    axi_write(32'(4 * DEPTH), 32'h12345678, 4'hF, 1'b0, 0, r);
    check("oor_wr_bresp", 32'(r), 32'd2);
    axi_write(32'h40, 32'h600D600D, 4'hF, 1'b1, 0, r);
    check("resv_survives_oor", 32'(r), 32'd1);
    axi_read(32'h40, 1'b0, 0, d, r, lat);
    check("mem40_excl", d, 32'h600D600D);
    axi_write(32'(4 * DEPTH - 4), 32'hCAFEF00D, 4'hF, 1'b0, 0, r);
    check("top_word_bresp", 32'(r), 32'd0);
    axi_read(32'(4 * DEPTH - 4), 1'b0, 0, d, r, lat);
    check("top_word_data", d, 32'hCAFEF00D);
    check("top_word_rresp", 32'(r), 32'd0);

    // Reset while waiting on a read
    axi_read(32'h10, 1'b1, 0, d, r, lat);
    araddr = 32'h10; arlock = 1'b0; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mid_rvalid", 32'(rvalid), 32'd0);
    end
    axi_read(32'h10, 1'b0, 0, d, r, lat);
    check("post_rst_data", d, 32'hDEADBEEF);
    check("post_rst_latency", 32'(lat), 32'(RL + 1));
    axi_write(32'h10, 32'h0, 4'hF, 1'b1, 0, r);
    check("post_rst_resv_gone", 32'(r), 32'd0);
    axi_read(32'h10, 1'b0, 0, d, r, lat);
    check("post_rst_mem10", d, 32'hDEADBEEF);

    // Randomized phase against the behavioural model
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_resv_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 32'h400 + 32'(4 * i);
      d = $urandom;
      model_write(a, d, 4'hF, 1'b0, er);
      axi_write(a, d, 4'hF, 1'b0, 0, r);
      check("rnd_init_bresp", 32'(r), 32'(er));
    end
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 3);
      k  = $urandom_range(0, 4);
      a  = (k < 4) ? 32'h400 + 32'(4 * k) : 32'h1000;
      a[1:0] = 2'($urandom_range(0, 3));
      lk = op[0];
      if (op < 2) begin
        hd = $urandom_range(0, 2);
        model_read(a, lk, ed, er);
        axi_read(a, lk, hd, d, r, lat);
        check("rnd_rdata", d, ed);
        check("rnd_rresp", 32'(r), 32'(er));
        check("rnd_latency", 32'(lat), 32'(RL + 1));
      end else begin
        d  = $urandom;
        s  = 4'($urandom_range(0, 15));
        wd = $urandom_range(0, 2);
        model_write(a, d, s, lk, er);
        axi_write(a, d, s, lk, wd, r);
        check("rnd_bresp", 32'(r), 32'(er));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
